// File: rtl/csa_resolve_pipe_if.sv
// Ready/valid channel pair for the carry-save resolve pipeline.
// The slave side is the pipeline. The master side is the producer/consumer around it.
interface csa_resolve_pipe_if #(
  parameter int unsigned K = 33
);
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] c;
  logic [K-1:0] s;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] r;
  logic         cout;

  modport master (
    output in_valid, c, s, out_ready,
    input  in_ready, out_valid, r, cout
  );

  modport slave (
    input  in_valid, c, s, out_ready,
    output in_ready, out_valid, r, cout
  );
endinterface

// File: rtl/csa_resolve_pipe.sv
// Resolves a carry-save pair into r = (s + c) mod 2^K plus carry-out.
// Carry propagation is split into SEG-bit segments, one segment per elastic pipeline stage.
module csa_resolve_pipe #(
  parameter int unsigned K   = 33,
  parameter int unsigned SEG = 11
) (
  input logic                clk,
  input logic                rst,
  csa_resolve_pipe_if.slave  bus
);

  localparam int unsigned NSEG = (K + SEG - 1) / SEG;
  localparam int unsigned LAST = NSEG - 1;

  for (genvar j = 0; j < NSEG; j++) begin : g_st
    localparam int unsigned LO = j * SEG;
    localparam int unsigned W  = (j == LAST) ? (K - LO) : SEG;
    localparam int unsigned WS = W + 1;

    logic         vld_q, vld_d;
    logic         ld_c, src_vld_c;
    logic         cy_q, cy_d;
    logic [K-1:0] acc_q, acc_d;
    logic [K-1:0] a_c;
    logic [W-1:0] b_c;
    logic         ci_c;
    logic [W:0]   seg_c;

    // acc holds resolved low segments plus still-pending upper bits of s
    if (j == 0) begin : g_src
      assign src_vld_c = bus.in_valid;
      assign a_c       = bus.s;
      assign b_c       = bus.c[W-1:0];
      assign ci_c      = 1'b0;
    end else begin : g_src
      assign src_vld_c = g_st[j-1].vld_q;
      assign a_c       = g_st[j-1].acc_q;
      assign b_c       = g_st[j-1].g_cv.cv_q[W-1:0];
      assign ci_c      = g_st[j-1].cy_q;
    end

    // A stage may load when empty or when its content moves on this cycle
    if (j == LAST) begin : g_ld
      assign ld_c = ~vld_q | bus.out_ready;
    end else begin : g_ld
      assign ld_c = ~vld_q | g_st[j+1].ld_c;
    end

    assign seg_c = WS'(a_c[LO +: W]) + WS'(b_c) + WS'(ci_c);

    always_comb begin
      vld_d = vld_q;
      acc_d = acc_q;
      cy_d  = cy_q;
      if (ld_c) begin
        vld_d = src_vld_c;
      end
      if (ld_c && src_vld_c) begin
        acc_d          = a_c;
        acc_d[LO +: W] = seg_c[W-1:0];
        cy_d           = seg_c[W];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        acc_q <= '0;
        cy_q  <= 1'b0;
      end else begin
        vld_q <= vld_d;
        acc_q <= acc_d;
        cy_q  <= cy_d;
      end
    end

    // Only the not-yet-consumed upper bits of c travel forward
    if (j < LAST) begin : g_cv
      localparam int unsigned CW = K - LO - W;

      logic [CW-1:0] cv_q, cv_d, cv_src_c;

      if (j == 0) begin : g_cs
        assign cv_src_c = bus.c[K-1:W];
      end else begin : g_cs
        assign cv_src_c = g_st[j-1].g_cv.cv_q[K-LO-1:W];
      end

      always_comb begin
        cv_d = cv_q;
        if (ld_c && src_vld_c) begin
          cv_d = cv_src_c;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cv_q <= '0;
        end else begin
          cv_q <= cv_d;
        end
      end
    end
  end

  assign bus.in_ready  = g_st[0].ld_c;
  assign bus.out_valid = g_st[LAST].vld_q;
  assign bus.r         = g_st[LAST].acc_q;
  assign bus.cout      = g_st[LAST].cy_q;

endmodule
